// File: rtl/sram_delay_scheduler_if.sv
// Pedal-side bundle of the delay-line SRAM scheduler: one sample in and two taps out per frame.
interface sram_delay_scheduler_if;
  logic        sample_strobe;
  logic [15:0] sample_in;
  logic [19:0] tap0_delay;
  logic [19:0] tap1_delay;
  logic        clear_overrun;
  logic [15:0] tap0_out;
  logic [15:0] tap1_out;
  logic        taps_valid;
  logic        busy;
  logic        overrun;

  modport master (
    output sample_strobe, sample_in, tap0_delay, tap1_delay, clear_overrun,
    input  tap0_out, tap1_out, taps_valid, busy, overrun
  );

  modport slave (
    input  sample_strobe, sample_in, tap0_delay, tap1_delay, clear_overrun,
    output tap0_out, tap1_out, taps_valid, busy, overrun
  );
endinterface

// File: rtl/sram_delay_scheduler.sv
// Owns the shared delay-effect SRAM: per audio frame it writes one sample into a circular
// buffer, then reads back two delayed taps.
module sram_delay_scheduler #(
  parameter int DEPTH       = 1048576,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  Clk,
  input  logic                  RESET,
  sram_delay_scheduler_if.slave pedal,
  output logic [19:0]           SRAM_ADDR,
  inout  wire  [15:0]           SRAM_DQ,
  output logic                  SRAM_WE_N,
  output logic                  SRAM_OE_N,
  output logic                  SRAM_CE_N,
  output logic                  SRAM_UB_N,
  output logic                  SRAM_LB_N
);

  localparam int          CW      = $clog2(WAIT_CYCLES + 1) + 1;
  localparam logic [20:0] DEPTH_W = 21'(DEPTH);
  localparam logic [19:0] LAST    = 20'(DEPTH - 1);

  typedef enum logic [3:0] {
    IDLE, W_SETUP, W_PULSE, W_HOLD, R0_ADDR, R0_WAIT, R1_ADDR, R1_WAIT, DONE
  } state_t;

  state_t        state, state_next;
  logic [19:0]   wr_ptr;
  logic [20:0]   fill, fill_next;
  logic [15:0]   sample_q;
  logic [19:0]   addr0_q, addr1_q;
  logic          zero0_q, zero1_q;
  logic [15:0]   tap0_hold;
  logic [CW-1:0] cnt;
  logic          dq_en;
  logic          accept;
  logic [20:0]   d0_c, d1_c;

  function automatic logic [20:0] clamp(input logic [19:0] d);
    logic [20:0] e;
    e = {1'b0, d};
    return (e >= DEPTH_W) ? DEPTH_W - 21'd1 : e;
  endfunction

  // The borrow bit of the 21-bit difference says the tap lies before the buffer start.
  function automatic logic [19:0] tap_addr(input logic [19:0] ptr, input logic [20:0] d);
    logic [20:0] diff;
    diff = {1'b0, ptr} - d;
    if (diff[20]) diff = diff + DEPTH_W;
    return diff[19:0];
  endfunction

  assign accept    = pedal.sample_strobe && (state == IDLE);
  assign d0_c      = clamp(pedal.tap0_delay);
  assign d1_c      = clamp(pedal.tap1_delay);
  assign fill_next = (fill == DEPTH_W) ? DEPTH_W : fill + 21'd1;

  assign pedal.busy = (state != IDLE);
  assign SRAM_DQ    = dq_en ? sample_q : 16'bz;
  assign SRAM_CE_N  = ~RESET;
  assign SRAM_UB_N  = ~RESET;
  assign SRAM_LB_N  = ~RESET;

  // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: defaulting state_next first means no path leaves it unassigned, so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pedal.sample_strobe) state_next = W_SETUP;
      W_SETUP: state_next = W_PULSE;
      W_PULSE: if (cnt == '0) state_next = W_HOLD;
      W_HOLD:  state_next = R0_ADDR;
      R0_ADDR: state_next = R0_WAIT;
      R0_WAIT: if (cnt == '0) state_next = R1_ADDR;
      R1_ADDR: state_next = R1_WAIT;
      R1_WAIT: if (cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read waits run one cycle longer than the write pulse so data settles after each address
  // change; this places taps_valid at edge 3*WAIT_CYCLES+6.
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      cnt <= '0;
    end else begin
      case (state)
        W_SETUP:          cnt <= CW'(WAIT_CYCLES - 1);
        R0_ADDR, R1_ADDR: cnt <= CW'(WAIT_CYCLES);
        default:          if (cnt != '0) cnt <= cnt - 1'b1;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      wr_ptr   <= '0;
      fill     <= '0;
      sample_q <= '0;
      addr0_q  <= '0;
      addr1_q  <= '0;
      zero0_q  <= 1'b0;
      zero1_q  <= 1'b0;
    end else begin
      if (accept) begin
        sample_q <= pedal.sample_in;
        addr0_q  <= tap_addr(wr_ptr, d0_c);
        addr1_q  <= tap_addr(wr_ptr, d1_c);
        zero0_q  <= (d0_c >= fill_next);
        zero1_q  <= (d1_c >= fill_next);
      end
      if (state == W_HOLD) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 20'd1;
        fill   <= fill_next;
      end
    end
  end

  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      tap0_hold        <= '0;
      pedal.tap0_out   <= '0;
      pedal.tap1_out   <= '0;
      pedal.taps_valid <= 1'b0;
      pedal.overrun    <= 1'b0;
    end else begin
      pedal.taps_valid <= 1'b0;
      if (state == R0_WAIT && cnt == '0) tap0_hold <= zero0_q ? 16'h0000 : SRAM_DQ;
      if (state == R1_WAIT && cnt == '0) begin
        pedal.tap0_out   <= tap0_hold;
        pedal.tap1_out   <= zero1_q ? 16'h0000 : SRAM_DQ;
        pedal.taps_valid <= 1'b1;
      end
      if (pedal.sample_strobe && state != IDLE) pedal.overrun <= 1'b1;
      else if (pedal.clear_overrun)             pedal.overrun <= 1'b0;
    end
  end

  // Pin controls are registered from state_next so the SRAM sees glitch-free strobes that
  // change together with the state.
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      dq_en     <= 1'b0;
    end else begin
      SRAM_WE_N <= (state_next != W_PULSE);
      SRAM_OE_N <= !(state_next inside {R0_ADDR, R0_WAIT, R1_ADDR, R1_WAIT});
      dq_en     <= (state_next inside {W_SETUP, W_PULSE, W_HOLD});
      case (state_next)
        W_SETUP: SRAM_ADDR <= wr_ptr;
        R0_ADDR: SRAM_ADDR <= addr0_q;
        R1_ADDR: SRAM_ADDR <= addr1_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_delay_scheduler.sv
// Directed bench: two schedulers (default depth and depth 8), each on its own behavioural SRAM.
module tb_sram_delay_scheduler;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  sram_delay_scheduler_if a_if ();
  sram_delay_scheduler_if b_if ();

  wire  [15:0] dq_a, dq_b;
  logic [19:0] addr_a, addr_b;
  logic        we_a, oe_a, ce_a, ub_a, lb_a;
  logic        we_b, oe_b, ce_b, ub_b, lb_b;
  logic [15:0] mem_a [0:1023];
  logic [15:0] mem_b [0:7];

  sram_delay_scheduler u_a (
    .Clk(clk), .RESET(rst_n), .pedal(a_if.slave),
    .SRAM_ADDR(addr_a), .SRAM_DQ(dq_a), .SRAM_WE_N(we_a), .SRAM_OE_N(oe_a),
    .SRAM_CE_N(ce_a), .SRAM_UB_N(ub_a), .SRAM_LB_N(lb_a)
  );

  sram_delay_scheduler #(.DEPTH(8), .WAIT_CYCLES(2)) u_b (
    .Clk(clk), .RESET(rst_n), .pedal(b_if.slave),
    .SRAM_ADDR(addr_b), .SRAM_DQ(dq_b), .SRAM_WE_N(we_b), .SRAM_OE_N(oe_b),
    .SRAM_CE_N(ce_b), .SRAM_UB_N(ub_b), .SRAM_LB_N(lb_b)
  );

  // Behavioural asynchronous-read SRAMs; unwritten cells read as DEAD.
  assign dq_a = (!oe_a && we_a && !ce_a) ? mem_a[addr_a[9:0]] : 16'bz;
  assign dq_b = (!oe_b && we_b && !ce_b) ? mem_b[addr_b[2:0]] : 16'bz;

  always @(posedge clk) begin
    if (!we_a && !ce_a) mem_a[addr_a[9:0]] <= dq_a;
    if (!we_b && !ce_b) mem_b[addr_b[2:0]] <= dq_b;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int          we_low, valid_edge, overlap;
  logic [19:0] we_addr, rd0_addr;
  logic [15:0] t0, t1;
  bit          rd_seen;

  // Strobe one frame into DUT sel (0 = a, 1 = b) and watch 16 edges. inj > 0 re-pulses a's
  // strobe (and optionally clear_overrun) so it is sampled at edge inj of the sequence.
  task automatic run_frame(input bit sel, input logic [15:0] s, input logic [19:0] d0,
                           input logic [19:0] d1, input int inj, input bit inj_clr);
    logic        wn, on, tv;
    logic [19:0] ad;
    @(negedge clk);
    if (sel) begin
      b_if.sample_strobe = 1'b1; b_if.sample_in = s; b_if.tap0_delay = d0; b_if.tap1_delay = d1;
    end else begin
      a_if.sample_strobe = 1'b1; a_if.sample_in = s; a_if.tap0_delay = d0; a_if.tap1_delay = d1;
    end
    @(posedge clk);
    #1;
    a_if.sample_strobe = 1'b0;
    b_if.sample_strobe = 1'b0;
    we_low = 0; valid_edge = -1; rd_seen = 0;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk);
      #1;
      a_if.sample_strobe = 1'b0;
      a_if.clear_overrun = 1'b0;
      wn = sel ? we_b : we_a;
      on = sel ? oe_b : oe_a;
      ad = sel ? addr_b : addr_a;
      tv = sel ? b_if.taps_valid : a_if.taps_valid;
      if (!wn) begin we_low++; we_addr = ad; end
      if (!on && !rd_seen) begin rd_seen = 1; rd0_addr = ad; end
      if (!on && !wn) overlap++;
      if (tv && valid_edge < 0) begin
        valid_edge = e;
        t0 = sel ? b_if.tap0_out : a_if.tap0_out;
        t1 = sel ? b_if.tap1_out : a_if.tap1_out;
      end
      if (e == inj - 1) begin
        a_if.sample_strobe = 1'b1;
        a_if.clear_overrun = inj_clr;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0; failures = 0; overlap = 0;
    for (int i = 0; i < 1024; i++) mem_a[i] = 16'hDEAD;
    for (int i = 0; i < 8; i++)    mem_b[i] = 16'hDEAD;
    a_if.sample_strobe = 1'b0; a_if.sample_in = '0; a_if.tap0_delay = '0; a_if.tap1_delay = '0;
    a_if.clear_overrun = 1'b0;
    b_if.sample_strobe = 1'b0; b_if.sample_in = '0; b_if.tap0_delay = '0; b_if.tap1_delay = '0;
    b_if.clear_overrun = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_strobes", {31'd0, we_a & oe_a & ce_a & ub_a & lb_a}, 32'd1);
    check("rst_outputs", {13'd0, a_if.taps_valid, a_if.busy, a_if.overrun, a_if.tap0_out | a_if.tap1_out}, 32'd0);
    check("rst_addr", {12'd0, addr_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ce_after_rst", {29'd0, ce_a, ub_a, lb_a}, 32'd0);

    run_frame(0, 16'h1234, 20'd0, 20'd0, 0, 0);
    check("f0_we_width", we_low, 2);
    check("f0_we_addr", {12'd0, we_addr}, 32'd0);
    check("f0_latency", valid_edge, 12);
    check("f0_taps", {t0, t1}, 32'h1234_1234);
    check("f0_idle_after", {31'd0, a_if.busy}, 32'd0);

    for (int n = 1; n <= 10; n++) begin
      run_frame(0, 16'(n), 20'd0, 20'd0, 0, 0);
      check("fill_tap0", {16'd0, t0}, n);
    end
    run_frame(0, 16'h000B, 20'd3, 20'd10, 0, 0);
    check("f11_taps", {t0, t1}, 32'h0008_0001);

    // Busy strobe at edge 5: ignored, no extra write, overrun sticks.
    run_frame(0, 16'h00C0, 20'd0, 20'd1, 5, 0);
    check("ovr_we_width", we_low, 2);
    check("ovr_taps", {t0, t1}, 32'h00C0_000B);
    check("ovr_set", {31'd0, a_if.overrun}, 32'd1);
    @(negedge clk);
    a_if.clear_overrun = 1'b1;
    @(posedge clk);
    #1;
    a_if.clear_overrun = 1'b0;
    check("ovr_clear", {31'd0, a_if.overrun}, 32'd0);
    run_frame(0, 16'h00C1, 20'd0, 20'd0, 3, 1);
    check("ovr_set_wins", {31'd0, a_if.overrun}, 32'd1);
    check("ovr2_tap0", {16'd0, t0}, 32'h00C1);
    @(negedge clk);
    a_if.clear_overrun = 1'b1;
    @(negedge clk);
    a_if.clear_overrun = 1'b0;

    // Reset during the write pulse.
    @(negedge clk);
    a_if.sample_strobe = 1'b1; a_if.sample_in = 16'h0BAD; a_if.tap0_delay = '0; a_if.tap1_delay = '0;
    @(posedge clk);
    #1;
    a_if.sample_strobe = 1'b0;
    @(posedge clk);
    #1;
    check("mid_we_low", {31'd0, we_a}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we_oe", {30'd0, we_a, oe_a}, 32'd3);
    check("mid_rst_dq_release", {31'd0, u_a.dq_en}, 32'd0);
    check("mid_rst_outputs", {13'd0, a_if.taps_valid, a_if.busy, a_if.overrun, a_if.tap0_out | a_if.tap1_out}, 32'd0);
    check("mid_rst_addr", {12'd0, addr_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, 16'h0D00, 20'd0, 20'd0, 0, 0);
    check("post_rst_addr", {12'd0, we_addr}, 32'd0);
    check("post_rst_tap0", {16'd0, t0}, 32'h0D00);

    // Fill boundary on a fresh buffer.
    pulse_reset();
    for (int n = 0; n < 4; n++) run_frame(0, 16'h0A00 + 16'(n), 20'd0, 20'd0, 0, 0);
    run_frame(0, 16'h0A04, 20'd5, 20'd4, 0, 0);
    check("fill_bound_taps", {t0, t1}, 32'h0000_0A00);

    // Wrap-around and clamp with DEPTH=8.
    for (int n = 0; n <= 8; n++) run_frame(1, 16'(n), 20'd0, 20'd0, 0, 0);
    run_frame(1, 16'd9, 20'd2, 20'd20, 0, 0);
    check("wrap_we_addr", {12'd0, we_addr}, 32'd1);
    check("wrap_rd_addr", {12'd0, rd0_addr}, 32'd7);
    check("wrap_taps", {t0, t1}, 32'h0007_0002);
    check("wrap_latency", valid_edge, 12);
    run_frame(1, 16'd10, 20'd0, 20'd0, 0, 0);
    check("wrap_ptr_next", {12'd0, we_addr}, 32'd2);
    check("wrap_tap0_next", {16'd0, t0}, 32'd10);

    check("no_oe_we_overlap", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
